// File: rtl/dut_core.sv
// Byte-wide change detector: XORs each sampled byte with the previous sample
// and delays the resulting bit-change mask through a DUT_PARAM-deep register
// pipeline before presenting it on data_out.
module dut_core #(
  parameter int DUT_PARAM = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int DATA_W = 8;

  if (DUT_PARAM < 1 || DUT_PARAM > 32) begin : g_param_check
    $error("dut_core: DUT_PARAM=%0d outside legal range 1..32", DUT_PARAM);
  end

  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] mask_d;
  logic [DATA_W-1:0] pipe_q [DUT_PARAM];

  // Bit-change mask between the current and the previous sample
  always_comb begin
    mask_d = data_in ^ prev_q;
  end

  // Previous-sample register and mask pipeline; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      for (int i = 0; i < DUT_PARAM; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      prev_q    <= data_in;
      pipe_q[0] <= mask_d;
      for (int i = 1; i < DUT_PARAM; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign data_out = pipe_q[DUT_PARAM-1];

endmodule

// File: tb/tb_dut_core.sv
// Directed bench for dut_core at pipeline depths 1, 2 and 32 driven in parallel.
module tb_dut_core;

  typedef struct {
    logic [7:0] din;
    logic [7:0] d;
  } vec_t;

  localparam int NVEC = 52;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] q1, q2, q32;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tbl [NVEC];

  dut_core #(.DUT_PARAM(1))  u_p1  (.clk(clk), .rst_n(rst_n), .data_in(din), .data_out(q1));
  dut_core #(.DUT_PARAM(2))  u_p2  (.clk(clk), .rst_n(rst_n), .data_in(din), .data_out(q2));
  dut_core #(.DUT_PARAM(32)) u_p32 (.clk(clk), .rst_n(rst_n), .data_in(din), .data_out(q32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int p, input int k,
                     input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s P=%0d step=%0d: got %h expected %h", name, p, k, act, exp);
    end
  endtask

  function automatic logic [7:0] out_of(input int p);
    case (p)
      1:       return q1;
      2:       return q2;
      default: return q32;
    endcase
  endfunction

  task automatic chk_all_zero(input string name, input int k);
    chk(name, 1, k, q1, 8'h00);
    chk(name, 2, k, q2, 8'h00);
    chk(name, 32, k, q32, 8'h00);
  endtask

  initial begin
    int params [3];
    params = '{1, 2, 32};

    // Hand-computed change masks d[k] = x[k] ^ x[k-1]
    tbl[0]  = '{8'h00, 8'h00};
    tbl[1]  = '{8'hA5, 8'hA5};
    tbl[2]  = '{8'h5A, 8'hFF};
    tbl[3]  = '{8'h00, 8'h5A};
    tbl[4]  = '{8'h00, 8'h00};
    tbl[5]  = '{8'h3C, 8'h3C};
    for (int i = 6; i <= 14; i++) tbl[i] = '{8'h3C, 8'h00};
    tbl[15] = '{8'h00, 8'h3C};
    tbl[16] = '{8'hFF, 8'hFF};
    tbl[17] = '{8'h0F, 8'hF0};
    tbl[18] = '{8'h0F, 8'h00};
    for (int i = 19; i < NVEC; i++) tbl[i] = '{8'h00, 8'h0F};
    tbl[19].d = 8'h0F;
    for (int i = 20; i < NVEC; i++) tbl[i].d = 8'h00;

    // Reset held with FF on the input
    rst_n = 1'b0;
    din   = 8'hFF;
    #1;
    chk_all_zero("reset_async", 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk_all_zero("reset_hold", k);
    end

    // Release with idle input
    @(negedge clk);
    rst_n = 1'b1;
    din   = 8'h00;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      chk_all_zero("idle", k);
    end

    // Table-driven sequence: output after edge k is d[k-P+1]
    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      din = tbl[k].din;
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        int idx;
        logic [7:0] exp;
        idx = k - params[j] + 1;
        exp = (idx >= 0) ? tbl[idx].d : 8'h00;
        chk("seq", params[j], k, out_of(params[j]), exp);
      end
    end

    // Mid-stream reset with FF in flight
    @(negedge clk);
    din = 8'hFF;
    @(posedge clk); #1;
    chk("ff_inflight", 1, 0, q1, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset_async", 0);
    @(posedge clk); #1;
    chk_all_zero("midreset_hold", 1);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 8'h81;
    for (int k = 0; k < 34; k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        chk("post_reset_81", params[j], k, out_of(params[j]),
            (k == params[j] - 1) ? 8'h81 : 8'h00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
